// File: rtl/instruction_encoder.sv
// Packs decoded RV64 R/I/S/B field sets into 32-bit machine words and streams them
// through a small FIFO into instruction memory over a ready-handshaked write port.
module instruction_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [63:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err,
    output logic                  done
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [PtrW:0] FullOcc = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_t;

    state_t          state_q;
    logic [31:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   occ_q;
    logic [31:0]     word;
    logic            legal, full, empty, accept, push, pop;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (fmt)
            2'b00: word = {funct7, rs2, rs1, funct3, rd, opcode};
            2'b01: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = (&imm[63:11]) | ~(|imm[63:11]);
            end
            2'b10: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = (&imm[63:11]) | ~(|imm[63:11]);
            end
            default: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                // Branch offsets are in halfwords, so bit 0 cannot be encoded.
                legal = ((&imm[63:12]) | ~(|imm[63:12])) & ~imm[0];
            end
        endcase
    end

    assign full      = (occ_q == FullOcc);
    assign empty     = (occ_q == '0);
    assign in_ready  = (state_q == StLoad) && !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign mem_we    = !empty;
    assign mem_wdata = fifo_mem[rd_ptr_q];
    assign pop       = mem_we && mem_ready;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      occ_q <= occ_q + (PtrW + 1)'(1);
            else if (pop && !push) occ_q <= occ_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            mem_addr <= BaseAddr;
            count    <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                if (count != '1) count <= count + (ADDR_WIDTH + 1)'(1);
            end
            if (accept && !legal) err <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StLoad;
                        mem_addr <= BaseAddr;
                        count    <= '0;
                        err      <= 1'b0;
                    end
                end
                StLoad:  if (finish) state_q <= StDrain;
                StDrain: begin
                    if (empty) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
